// File: rtl/clock_mode_sequencer.sv
// clock_mode_sequencer
// Drives MMCM preset changes: selects the preset, pulses the MMCM reset, waits
// for a synchronized lock and releases the downstream domain only after the
// new clock has stayed locked for POST_LOCK_CYCLES. Brings up DEFAULT_MODE
// after reset and re-locks automatically if lock drops while running.
module clock_mode_sequencer #(
    parameter int NUM_MODES        = 7,
    parameter int DEFAULT_MODE     = 0,
    parameter int MMCM_RST_CYCLES  = 4,
    parameter int LOCK_TIMEOUT     = 65535,
    parameter int POST_LOCK_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [2:0] req_sel,
    output logic       req_ready,
    input  logic       mmcm_locked,
    output logic       mmcm_rst,
    output logic [2:0] cfg_sel,
    output logic       cfg_load,
    output logic       domain_rst_n,
    output logic       busy,
    output logic       done,
    output logic       err_timeout,
    output logic       err_invalid,
    output logic       lock_lost
);

    // One counter serves the reset, lock-wait and hold phases.
    localparam int MAX_AB  = (LOCK_TIMEOUT > POST_LOCK_CYCLES) ? LOCK_TIMEOUT : POST_LOCK_CYCLES;
    localparam int MAX_CNT = (MAX_AB > MMCM_RST_CYCLES) ? MAX_AB : MMCM_RST_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(POST_LOCK_CYCLES - 1);
    localparam logic [2:0]       DEF_SEL   = 3'(DEFAULT_MODE);

    if (MMCM_RST_CYCLES < 3) begin : g_rst_cycles_check
        $error("MMCM_RST_CYCLES must be at least 3");
    end

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_MMCM_RST  = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    state_t           state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             sync1_r, locked_sync_r;

    logic       req_ready_r, mmcm_rst_r, cfg_load_r, domain_rst_n_r, busy_r;
    logic       done_r, err_timeout_r, err_invalid_r, lock_lost_r;
    logic [2:0] cfg_sel_r;

    logic       req_ready_s, mmcm_rst_s, cfg_load_s, domain_rst_n_s, busy_s;
    logic       done_s, err_timeout_s, err_invalid_s, lock_lost_s;
    logic [2:0] cfg_sel_s;

    logic lock_loss_s, accept_s, sel_ok_s, accept_ok_s, timeout_s, hold_done_s;

    // Lock loss only matters once the domain is running; it pre-empts requests.
    assign lock_loss_s = (state_r == ST_IDLE) && domain_rst_n_r && !locked_sync_r;
    assign accept_s    = (state_r == ST_IDLE) && req_ready_r && req_valid && !lock_loss_s;
    assign sel_ok_s    = ({29'd0, req_sel} < 32'(NUM_MODES));
    assign accept_ok_s = accept_s && sel_ok_s;
    assign timeout_s   = (state_r == ST_WAIT_LOCK) && !locked_sync_r && (cnt_r == TO_LAST);
    assign hold_done_s = (state_r == ST_HOLD) && locked_sync_r && (cnt_r == HOLD_LAST);

    // Two-flop synchronizer for the asynchronous MMCM lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r       <= 1'b0;
            locked_sync_r <= 1'b0;
        end else begin
            sync1_r       <= mmcm_locked;
            locked_sync_r <= sync1_r;
        end
    end

    // State register; reset lands in LOAD so bring-up reuses the switch path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (lock_loss_s) begin
                    next_state_s = ST_MMCM_RST;
                end else if (accept_ok_s) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                next_state_s = ST_MMCM_RST;
            end
            ST_MMCM_RST: begin
                if (cnt_r == RST_LAST) begin
                    next_state_s = ST_WAIT_LOCK;
                end else begin
                    next_state_s = ST_MMCM_RST;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_sync_r) begin
                    next_state_s = ST_HOLD;
                end else if (timeout_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT_LOCK;
                end
            end
            ST_HOLD: begin
                if (!locked_sync_r) begin
                    next_state_s = ST_MMCM_RST;
                end else if (hold_done_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: begin
                next_state_s = ST_LOAD;
            end
        endcase
    end

    // Phase counter: restarts on every state change, counts in timed states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (next_state_s != state_r) begin
            cnt_r <= CNT_ZERO;
        end else if ((state_r == ST_MMCM_RST) || (state_r == ST_WAIT_LOCK) || (state_r == ST_HOLD)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= CNT_ZERO;
        end
    end

    // Output decode from the upcoming state so registered outputs line up with it.
    always_comb begin
        // req_ready rises one cycle after IDLE entry, so done/timeout land first.
        req_ready_s   = (state_r == ST_IDLE) && (next_state_s == ST_IDLE);
        busy_s        = (next_state_s != ST_IDLE);
        mmcm_rst_s    = (next_state_s == ST_LOAD) || (next_state_s == ST_MMCM_RST);
        cfg_load_s    = (next_state_s == ST_LOAD);
        done_s        = hold_done_s;
        err_invalid_s = accept_s && !sel_ok_s;

        if (accept_ok_s) begin
            cfg_sel_s = req_sel;
        end else begin
            cfg_sel_s = cfg_sel_r;
        end

        if (next_state_s == ST_IDLE) begin
            domain_rst_n_s = hold_done_s ? 1'b1 : domain_rst_n_r;
        end else begin
            domain_rst_n_s = 1'b0;
        end

        if (timeout_s) begin
            err_timeout_s = 1'b1;
        end else if (accept_ok_s) begin
            err_timeout_s = 1'b0;
        end else begin
            err_timeout_s = err_timeout_r;
        end

        if (lock_loss_s) begin
            lock_lost_s = 1'b1;
        end else if (accept_ok_s) begin
            lock_lost_s = 1'b0;
        end else begin
            lock_lost_s = lock_lost_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready_r    <= 1'b0;
            mmcm_rst_r     <= 1'b1;
            cfg_sel_r      <= DEF_SEL;
            cfg_load_r     <= 1'b0;
            domain_rst_n_r <= 1'b0;
            busy_r         <= 1'b1;
            done_r         <= 1'b0;
            err_timeout_r  <= 1'b0;
            err_invalid_r  <= 1'b0;
            lock_lost_r    <= 1'b0;
        end else begin
            req_ready_r    <= req_ready_s;
            mmcm_rst_r     <= mmcm_rst_s;
            cfg_sel_r      <= cfg_sel_s;
            cfg_load_r     <= cfg_load_s;
            domain_rst_n_r <= domain_rst_n_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
            err_timeout_r  <= err_timeout_s;
            err_invalid_r  <= err_invalid_s;
            lock_lost_r    <= lock_lost_s;
        end
    end

    assign req_ready    = req_ready_r;
    assign mmcm_rst     = mmcm_rst_r;
    assign cfg_sel      = cfg_sel_r;
    assign cfg_load     = cfg_load_r;
    assign domain_rst_n = domain_rst_n_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err_timeout  = err_timeout_r;
    assign err_invalid  = err_invalid_r;
    assign lock_lost    = lock_lost_r;

endmodule

// File: doc/clock_mode_sequencer.md
# clock_mode_sequencer

Sequences MMCM clock-mode changes between the presets in `clock_modes_pkg` (index 0..6 in declaration order: 100, 50, 40, 33.3, 25.175, 10 and 5 MHz). It accepts a mode request and drives the config-select and MMCM reset. It waits for a synchronized lock, then holds the downstream clock domain in reset until the new clock has been stable for a programmable interval. It runs on the free-running input clock. After reset it brings the design up in the default mode and recovers automatically from loss of lock.

## Interface
Parameters:
- `NUM_MODES`, default 7: number of valid presets; `sel >= NUM_MODES` is invalid.
- `DEFAULT_MODE`, default 0: mode applied after reset.
- `MMCM_RST_CYCLES`, default 4: cycles spent in the reset phase after LOAD (minimum 3, checked at elaboration).
- `LOCK_TIMEOUT`, default 65535: maximum WAIT_LOCK cycles before the attempt is abandoned.
- `POST_LOCK_CYCLES`, default 256: stable-lock cycles before the downstream domain is released.

Ports (reset is synchronous and active-low):
- `clk` in 1: input (reference) clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: mode request valid.
- `req_sel` in 3: requested preset index.
- `req_ready` out 1: high only in IDLE.
- `mmcm_locked` in 1: asynchronous MMCM lock; synchronized internally with 2 flops.
- `mmcm_rst` out 1: MMCM reset, active-high.
- `cfg_sel` out 3: preset index driving the config mux / DRP writer.
- `cfg_load` out 1: one-cycle pulse when `cfg_sel` changes.
- `domain_rst_n` out 1: downstream-domain reset, active-low.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a switch completes.
- `err_timeout` out 1: sticky; lock not achieved.
- `err_invalid` out 1: one-cycle pulse; an invalid `req_sel` was accepted.
- `lock_lost` out 1: sticky; lock dropped while running.

## Operation
- States: IDLE, LOAD, MMCM_RST, WAIT_LOCK, HOLD.
- Reset values:
  - state = LOAD with pending sel = `DEFAULT_MODE`.
  - `cfg_sel` = `DEFAULT_MODE`, `mmcm_rst`=1, `domain_rst_n`=0, `busy`=1.
  - `req_ready`, `cfg_load`, `done`, `err_*` and `lock_lost` = 0; sync flops = 0.
- IDLE: a request is accepted when `req_valid && req_ready`.
  - Valid sel: latch it, clear `err_timeout` and `lock_lost`, go to LOAD.
  - Invalid sel: pulse `err_invalid` and stay in IDLE with no other change.
- LOAD, 1 cycle: update `cfg_sel`, pulse `cfg_load`, `mmcm_rst`=1, `domain_rst_n`=0, go to MMCM_RST.
- MMCM_RST, `MMCM_RST_CYCLES` cycles: `mmcm_rst`=1. Then clear the counter and go to WAIT_LOCK.
- WAIT_LOCK: `mmcm_rst`=0; the counter increments each cycle.
  - `locked_sync`=1: go to HOLD with the counter cleared.
  - Counter reaches `LOCK_TIMEOUT`: set `err_timeout` and go to IDLE. `domain_rst_n` stays 0 and `cfg_sel` is retained.
- HOLD: `domain_rst_n`=0; the counter increments each cycle.
  - `locked_sync`=0: go to MMCM_RST (relock with the same `cfg_sel`).
  - Counter reaches `POST_LOCK_CYCLES`: `domain_rst_n`=1, pulse `done`, go to IDLE.
- IDLE with `domain_rst_n`=1 and `locked_sync`=0 (lock loss): set `lock_lost`, `domain_rst_n`=0, go to MMCM_RST. Lock loss takes priority over a same-cycle request; that request is not accepted.
- IDLE after a timeout (`domain_rst_n`=0): lock is ignored; only a new request restarts the sequence.
- `rst_n` low mid-switch: return to the reset values immediately and redo bring-up with `DEFAULT_MODE`.

## Timing
- Request accepted at cycle T:
  - T+1: LOAD; `cfg_load`=1 and the new `cfg_sel` is visible.
  - `mmcm_rst` is high for 1+`MMCM_RST_CYCLES` cycles.
- Lock path latency:
  - `mmcm_locked` rising to `locked_sync` high: 2 cycles.
  - Entry into HOLD: 1 further cycle.
  - `domain_rst_n` rises `POST_LOCK_CYCLES` cycles after entering HOLD.
  - `done` is coincident with the first cycle of `domain_rst_n`=1.
- Minimum switch time:
  - T to `done` = 1 + `MMCM_RST_CYCLES` + 3 + `POST_LOCK_CYCLES` cycles.
  - Valid only if `mmcm_locked` is high when `mmcm_rst` falls; in practice lock takes longer.
- `err_invalid` is asserted in cycle T+1.
- `req_ready` returns to 1 in the cycle after `done` or after `err_timeout` is set.
- All outputs are registered.

## Test plan
- Reset bring-up: release `rst_n`; model locks 20 cycles after `mmcm_rst` falls.
  - Require `cfg_sel`=0 and `mmcm_rst` high for 5 cycles.
  - Require `domain_rst_n` to rise exactly 256 cycles after HOLD entry, with a single `done`.
- Switch to sel=4 (25.175 MHz) in IDLE:
  - Require `req_ready` to drop, `cfg_load` pulse at T+1 with `cfg_sel`=4, and `domain_rst_n` low throughout.
  - Require `done` then `req_ready`=1.
- Timeout: `LOCK_TIMEOUT`=100, model never locks.
  - Require `err_timeout`=1 exactly 100 cycles into WAIT_LOCK, IDLE, `domain_rst_n`=0.
  - A following valid request clears `err_timeout`.
- Invalid sel=7:
  - Require an `err_invalid` pulse, `cfg_sel` unchanged, no `mmcm_rst`, `busy`=0.
- Lock loss in IDLE (drop `mmcm_locked` for 10 cycles):
  - Require `lock_lost`=1, `domain_rst_n`=0 within 3 cycles, and automatic relock with the same `cfg_sel`.
- Glitch during HOLD (drop lock at hold count 100):
  - Require re-entry into MMCM_RST and the hold count restarting from 0.
- Mid-switch reset: assert `rst_n`=0 in WAIT_LOCK.
  - Require all outputs at reset values next cycle and bring-up with `cfg_sel`=0.
